// File: rtl/mod60_pkg.sv
// Shared types and constants for the mod-60 BCD timer/stopwatch.
package mod60_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [3:0] ONES_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX = 4'd5;

    // Prescaler register width; never narrower than one bit.
    function automatic int presc_w(input int p);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit counting 0..MAX in either direction, with preload and clear.
module bcd_digit #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       dir,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       clr,
    output logic [3:0] digit,
    output logic       wrap
);

    // Wrap flag feeds the next digit's enable, so it is combinational.
    assign wrap = dir ? (digit == 4'd0) : (digit == MAX);

    // Digit register: clear beats load beats step; preloads clamp to MAX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit <= 4'd0;
        end else if (clr) begin
            digit <= 4'd0;
        end else if (load) begin
            digit <= (load_val > MAX) ? MAX : load_val;
        end else if (en) begin
            if (wrap)
                digit <= dir ? MAX : 4'd0;
            else
                digit <= dir ? digit - 4'd1 : digit + 4'd1;
        end
    end

endmodule

// File: rtl/mod60_timer_ctrl.sv
// Mod-60 BCD stopwatch/timer: prescaler, run/pause/done FSM and digit cascade.
module mod60_timer_ctrl
    import mod60_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_ones,
    input  logic [3:0] load_tens,
    input  logic       dir,
    output logic [3:0] cnt_10,
    output logic [3:0] cnt_6,
    output logic       cout,
    output logic       done,
    output logic [1:0] state
);

    localparam int PW = presc_w(PRESCALE);
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    state_t          state_q, state_nxt;
    logic [PW-1:0]   presc_q, presc_nxt;
    logic            cout_q, cout_nxt, done_q;
    logic            step, dig_clr, dig_load;
    logic            ones_wrap, tens_wrap;
    logic            zero, at59, at01;

    assign zero = (cnt_10 == 4'd0) && (cnt_6 == 4'd0);
    assign at59 = (cnt_10 == ONES_MAX) && (cnt_6 == TENS_MAX);
    assign at01 = (cnt_10 == 4'd1) && (cnt_6 == 4'd0);

    bcd_digit #(.MAX(ONES_MAX)) u_ones (
        .clk(clk), .rst(rst), .en(step), .dir(dir), .load(dig_load),
        .load_val(load_ones), .clr(dig_clr), .digit(cnt_10), .wrap(ones_wrap)
    );

    // Tens only moves when the ones digit rolls over on an actual step.
    bcd_digit #(.MAX(TENS_MAX)) u_tens (
        .clk(clk), .rst(rst), .en(step & ones_wrap), .dir(dir), .load(dig_load),
        .load_val(load_tens), .clr(dig_clr), .digit(cnt_6), .wrap(tens_wrap)
    );

    // State, prescaler and flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            presc_q <= presc_nxt;
            cout_q  <= cout_nxt;
            done_q  <= (state_nxt == DONE);
        end
    end

    // Command decode in priority order clear > load > stop > start > step.
    always_comb begin
        state_nxt = state_q;
        presc_nxt = presc_q;
        cout_nxt  = 1'b0;
        step      = 1'b0;
        dig_clr   = 1'b0;
        dig_load  = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
            presc_nxt = '0;
            dig_clr   = 1'b1;
        end else if (load && state_q != RUN) begin
            dig_load = 1'b1;
        end else if (stop && state_q == RUN) begin
            state_nxt = PAUSE;
        end else if (start && state_q != RUN) begin
            // Counting down from 00 has nothing to do: finish immediately.
            if (dir && zero) begin
                state_nxt = DONE;
                presc_nxt = '0;
            end else begin
                state_nxt = RUN;
            end
        end else if (state_q == RUN) begin
            if (presc_q == PMAX) begin
                presc_nxt = '0;
                if (dir && zero) begin
                    // Direction flipped to down while parked at 00: never wrap to 59.
                    state_nxt = DONE;
                end else begin
                    step     = 1'b1;
                    cout_nxt = !dir && at59;
                    if (dir && at01)
                        state_nxt = DONE;
                end
            end else begin
                presc_nxt = presc_q + 1'b1;
            end
        end
    end

    assign cout  = cout_q;
    assign done  = done_q;
    assign state = state_q;

endmodule

// File: tb/tb_mod60_timer_ctrl.sv
// Directed bench for mod60_timer_ctrl with a per-cycle expectation queue.
module tb_mod60_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 0, stop = 0, clear = 0, load = 0, dir = 0;
    logic [3:0] load_ones = 0, load_tens = 0;

    logic [3:0] o1, t1, o4, t4;
    logic       c1, d1, c4, d4;
    logic [1:0] s1, s4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] ones;
        logic [3:0] tens;
        logic       cout;
        logic [1:0] st;
        bit         sel;
        string      tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mod60_timer_ctrl #(.PRESCALE(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .load(load),
        .load_ones(load_ones), .load_tens(load_tens), .dir(dir),
        .cnt_10(o1), .cnt_6(t1), .cout(c1), .done(d1), .state(s1)
    );

    mod60_timer_ctrl #(.PRESCALE(4)) u4 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .load(load),
        .load_ones(load_ones), .load_tens(load_tens), .dir(dir),
        .cnt_10(o4), .cnt_6(t4), .cout(c4), .done(d4), .state(s4)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic chk_all(input string tag, input bit sel, input logic [3:0] wo,
                           input logic [3:0] wt, input logic wc, input logic [1:0] ws);
        logic [3:0] oo, ot;
        logic       oc, od;
        logic [1:0] os;
        oo = sel ? o4 : o1;
        ot = sel ? t4 : t1;
        oc = sel ? c4 : c1;
        od = sel ? d4 : d1;
        os = sel ? s4 : s1;
        chk({tag, ".ones"}, oo, wo);
        chk({tag, ".tens"}, ot, wt);
        chk({tag, ".cout"}, {3'b0, oc}, {3'b0, wc});
        chk({tag, ".done"}, {3'b0, od}, {3'b0, (ws == 2'b11)});
        chk({tag, ".state"}, {2'b0, os}, {2'b0, ws});
    endtask

    // Push what the next edge must produce, clock it, then retire it.
    task automatic tick(input string tag, input bit sel, input logic [3:0] wo,
                        input logic [3:0] wt, input logic wc, input logic [1:0] ws);
        exp_t e;
        sb.push_back('{ones: wo, tens: wt, cout: wc, st: ws, sel: sel, tag: tag});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk_all(e.tag, e.sel, e.ones, e.tens, e.cout, e.st);
    endtask

    task automatic drive(input logic st, input logic sp, input logic cl, input logic ld,
                         input logic [3:0] lo, input logic [3:0] lt, input logic dr);
        start = st; stop = sp; clear = cl; load = ld;
        load_ones = lo; load_tens = lt; dir = dr;
    endtask

    initial begin
        // Reset state of both instances while rst is held.
        #2;
        chk_all("rst_p1", 1'b0, 4'd0, 4'd0, 1'b0, 2'b00);
        chk_all("rst_p4", 1'b1, 4'd0, 4'd0, 1'b0, 2'b00);
        #5 rst = 1'b1;
        tick("idle", 1'b0, 4'd0, 4'd0, 1'b0, 2'b00);

        // Free-running up count at one step per cycle, including the 59->00 wrap.
        drive(1, 0, 0, 0, 0, 0, 0);
        tick("up_start", 1'b0, 4'd0, 4'd0, 1'b0, 2'b01);
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 61; i++) begin
            tick($sformatf("up%0d", i), 1'b0, 4'(i % 10), 4'((i % 60) / 10),
                 (i == 60), 2'b01);
        end
        drive(0, 0, 1, 0, 0, 0, 0);
        tick("clr1", 1'b0, 4'd0, 4'd0, 1'b0, 2'b00);

        // Preload 03 and count down to DONE.
        drive(0, 0, 0, 1, 4'd3, 4'd0, 1);
        tick("ld03", 1'b0, 4'd3, 4'd0, 1'b0, 2'b00);
        drive(1, 0, 0, 0, 0, 0, 1);
        tick("dn_start", 1'b0, 4'd3, 4'd0, 1'b0, 2'b01);
        drive(0, 0, 0, 0, 0, 0, 1);
        tick("dn02", 1'b0, 4'd2, 4'd0, 1'b0, 2'b01);
        tick("dn01", 1'b0, 4'd1, 4'd0, 1'b0, 2'b01);
        tick("dn00", 1'b0, 4'd0, 4'd0, 1'b0, 2'b11);
        tick("dn_hold", 1'b0, 4'd0, 4'd0, 1'b0, 2'b11);
        // start down at 00 stays DONE without wrapping.
        drive(1, 0, 0, 0, 0, 0, 1);
        tick("dn_restart0", 1'b0, 4'd0, 4'd0, 1'b0, 2'b11);

        // Clear coincident with the 59->00 step.
        drive(0, 0, 0, 1, 4'd8, 4'd5, 0);
        tick("ld58", 1'b0, 4'd8, 4'd5, 1'b0, 2'b11);
        drive(1, 0, 0, 0, 0, 0, 0);
        tick("run58", 1'b0, 4'd8, 4'd5, 1'b0, 2'b01);
        drive(0, 0, 0, 0, 0, 0, 0);
        tick("run59", 1'b0, 4'd9, 4'd5, 1'b0, 2'b01);
        drive(0, 0, 1, 0, 0, 0, 0);
        tick("clr_wrap", 1'b0, 4'd0, 4'd0, 1'b0, 2'b00);

        // Out-of-range preload clamps to 59.
        drive(0, 0, 0, 1, 4'd12, 4'd7, 0);
        tick("ld_clamp", 1'b0, 4'd9, 4'd5, 1'b0, 2'b00);
        drive(0, 0, 1, 0, 0, 0, 0);
        tick("clr2", 1'b1, 4'd0, 4'd0, 1'b0, 2'b00);

        // PRESCALE=4: steps land 4 edges after start, then every 4.
        drive(1, 0, 0, 0, 0, 0, 0);
        tick("p4_start", 1'b1, 4'd0, 4'd0, 1'b0, 2'b01);
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            tick($sformatf("p4_e%0d", i), 1'b1, 4'(i / 4), 4'd0, 1'b0, 2'b01);
        end
        // Prescaler now at 2; stop, hold, resume: step two cycles later.
        drive(0, 1, 0, 0, 0, 0, 0);
        tick("p4_stop", 1'b1, 4'd2, 4'd0, 1'b0, 2'b10);
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            tick($sformatf("p4_hold%0d", i), 1'b1, 4'd2, 4'd0, 1'b0, 2'b10);
        drive(1, 0, 0, 0, 0, 0, 0);
        tick("p4_resume", 1'b1, 4'd2, 4'd0, 1'b0, 2'b01);
        drive(0, 0, 0, 0, 0, 0, 0);
        tick("p4_r1", 1'b1, 4'd2, 4'd0, 1'b0, 2'b01);
        tick("p4_r2", 1'b1, 4'd3, 4'd0, 1'b0, 2'b01);
        tick("p4_r3", 1'b1, 4'd3, 4'd0, 1'b0, 2'b01);
        tick("p4_r4", 1'b1, 4'd3, 4'd0, 1'b0, 2'b01);
        tick("p4_r5", 1'b1, 4'd3, 4'd0, 1'b0, 2'b01);
        // Stop on the step-due edge: no step, step fires first cycle after resume.
        drive(0, 1, 0, 0, 0, 0, 0);
        tick("p4_stop_due", 1'b1, 4'd3, 4'd0, 1'b0, 2'b10);
        drive(1, 0, 0, 0, 0, 0, 0);
        tick("p4_resume2", 1'b1, 4'd3, 4'd0, 1'b0, 2'b01);
        drive(0, 0, 0, 0, 0, 0, 0);
        tick("p4_after", 1'b1, 4'd4, 4'd0, 1'b0, 2'b01);

        // Async reset between edges in the middle of a run.
        drive(0, 0, 1, 0, 0, 0, 0);
        tick("clr3", 1'b0, 4'd0, 4'd0, 1'b0, 2'b00);
        drive(1, 0, 0, 0, 0, 0, 0);
        tick("ar_start", 1'b0, 4'd0, 4'd0, 1'b0, 2'b01);
        drive(0, 0, 0, 0, 0, 0, 0);
        tick("ar01", 1'b0, 4'd1, 4'd0, 1'b0, 2'b01);
        tick("ar02", 1'b0, 4'd2, 4'd0, 1'b0, 2'b01);
        tick("ar03", 1'b0, 4'd3, 4'd0, 1'b0, 2'b01);
        #3 rst = 1'b0;
        #1;
        chk_all("ar_rst_p1", 1'b0, 4'd0, 4'd0, 1'b0, 2'b00);
        chk_all("ar_rst_p4", 1'b1, 4'd0, 4'd0, 1'b0, 2'b00);
        #1 rst = 1'b1;
        tick("ar_idle", 1'b0, 4'd0, 4'd0, 1'b0, 2'b00);
        drive(1, 0, 0, 0, 0, 0, 0);
        tick("ar_restart", 1'b0, 4'd0, 4'd0, 1'b0, 2'b01);
        drive(0, 0, 0, 0, 0, 0, 0);
        tick("ar_r01", 1'b0, 4'd1, 4'd0, 1'b0, 2'b01);
        tick("ar_r02", 1'b0, 4'd2, 4'd0, 1'b0, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod60_timer_ctrl.md
# mod60_timer_ctrl

Synchronous controller for the two-digit BCD mod-60 counter (ones 0–9, tens 0–5), configurable as an up-counting stopwatch or a down-counting timer. It replaces ripple-clocked cascading with a single-clock, enable-driven cascade and adds a prescaler, a run/pause/done state machine, preload, and clean wrap and done flags. It sits between the user control logic (buttons/tick source) and the display/decoder path.

## Interface
- PRESCALE, 1: clk cycles per count step while running; legal values are ≥1.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  level-sampled; enter/resume RUN.
- stop  in  1  level-sampled; RUN -> PAUSE.
- clear  in  1  level-sampled; zero digits and go to IDLE from any state.
- load  in  1  level-sampled; preload digits (IDLE/PAUSE/DONE only).
- load_ones  in  4  BCD ones preload value.
- load_tens  in  4  BCD tens preload value.
- dir  in  1  count direction: 0 = up, 1 = down; sampled at each step.
- cnt_10  out  4  ones digit, 0–9.
- cnt_6  out  4  tens digit, 0–5.
- cout  out  1  one-cycle pulse on up-wrap 59->00.
- done  out  1  high while in DONE.
- state  out  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.

## Operation
- Reset (rst=0, async): state=IDLE, cnt_10=0, cnt_6=0, cout=0, done=0, prescaler=0.
- Command priority per cycle: clear > load > stop > start > step.
- IDLE: start -> RUN. load -> digits take load values.
- RUN:
  - Prescaler counts 0..PRESCALE-1. A step occurs on the cycle where it equals PRESCALE-1, then it returns to 0.
  - stop -> PAUSE. The prescaler value is held.
  - load is ignored.
- PAUSE: start -> RUN. The prescaler resumes from its held value. load is allowed.
- DONE: done=1. start -> RUN, which is only meaningful after load or dir=0. load is allowed; the state stays DONE until start or clear.
- clear in any state -> IDLE, digits 00, prescaler 0, cout=0.
- Up step:
  - ones+1. At ones=9: ones=0 and tens+1.
  - At 59: 00 and cout=1 for exactly one cycle; state stays RUN (free-running).
- Down step:
  - ones-1. At ones=0: ones=9 and tens-1.
  - A step that lands on 00 moves state to DONE on the same edge.
- start with dir=1 and digits 00 (from IDLE/PAUSE) -> DONE directly; no step, no wrap.
- Out-of-range preload: ones>9 clamps to 9; tens>5 clamps to 5.
- dir may change at any time and takes effect at the next step. The down direction never wraps 00->59.

## Timing
- start sampled high at edge k: state=RUN after edge k. First step lands at edge k+PRESCALE, then every PRESCALE cycles.
- PRESCALE=1: one step per RUN cycle.
- Digits, cout, done and state are all registered and update on the same edge as the causing step or command. Latency from sampled input to output is one edge.
- cout is high only in the cycle where digits first read 00 after 59. It never asserts in down mode, on load, or on clear.
- Simultaneous stop and step-due edge: stop wins, no step, prescaler holds at PRESCALE-1. The step fires on the first RUN cycle after resume.
- Simultaneous clear and wrap: clear wins, cout=0.
- Reset mid-count: all outputs return to reset values immediately, independent of clk.

## Structure
- Package mod60_pkg:
  - state encoding constants (IDLE/RUN/PAUSE/DONE);
  - ONES_MAX=4'd9, TENS_MAX=4'd5;
  - prescaler width = max(1, $clog2(PRESCALE)).
- Sub-module bcd_digit, parameterised by MAX, instantiated twice. Its ports:
  - inputs: en, dir, load, load_val, clr;
  - outputs: digit value and a combinational wrap flag (at MAX going up, at 0 going down).
- The tens digit's en is the ones digit's en ANDed with the ones digit's wrap flag. There are no derived clocks.
- The FSM, prescaler, cout and done registers live in the top.

## Test plan
- Reset, then start with dir=0, PRESCALE=1: digits 00->01->…->59->00 over 60 cycles; cout high exactly one cycle with digits=00; state stays 01.
- PRESCALE=4, start at edge k: first change to 01 at edge k+4, to 02 at edge k+8.
- load ones=3, tens=0 in IDLE, dir=1, start: digits 03,02,01,00, with done=1 and state=11 on the 00 edge; no cout.
- Pause with PRESCALE=4: stop after 2 prescaler cycles, hold 10 cycles with digits frozen, start again: next step 2 cycles later.
- Assert clear together with the 59->00 step: digits 00, cout=0, state=00. Separately, load ones=12, tens=7 -> digits read 59.
- Pull rst low mid-RUN between clock edges: outputs read 00/0/0/00 before the next edge; after release, start resumes counting from 00.
